// File: rtl/arbitrated_multiport_ram_if.sv
// Request/grant bus for the arbitrated multiport RAM: per-port read address
// channel, read data return and per-port write channel, all as flat vectors.
interface arbitrated_multiport_ram_if #(
   parameter int READ_PORTS  = 3,
   parameter int WRITE_PORTS = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4
);
   logic [READ_PORTS*ADDR_WIDTH-1:0]  r_addr;
   logic [READ_PORTS-1:0]             r_avalid;
   logic [READ_PORTS-1:0]             r_aready;
   logic [READ_PORTS-1:0]             r_dvalid;
   logic [READ_PORTS*DATA_WIDTH-1:0]  r_data;
   logic [WRITE_PORTS*ADDR_WIDTH-1:0] w_addr;
   logic [WRITE_PORTS*DATA_WIDTH-1:0] w_data;
   logic [WRITE_PORTS-1:0]            w_valid;
   logic [WRITE_PORTS-1:0]            w_ready;

   modport master (
      output r_addr, r_avalid, w_addr, w_data, w_valid,
      input  r_aready, r_dvalid, r_data, w_ready
   );

   modport slave (
      input  r_addr, r_avalid, w_addr, w_data, w_valid,
      output r_aready, r_dvalid, r_data, w_ready
   );
endinterface

// File: rtl/arbitrated_multiport_ram.sv
// Pseudo-dual-port RAM shared by several read and write requesters.
// Each side has its own round-robin arbiter; one read and one write can be
// accepted per cycle. Reads are read-first and return DATA_LAT cycles later
// on the lane of the granted port.
module arbitrated_multiport_ram #(
   parameter int READ_PORTS  = 3,
   parameter int WRITE_PORTS = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_LAT    = 1
) (
   input logic                        clk,
   input logic                        rst,
   arbitrated_multiport_ram_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int RP_W  = (READ_PORTS  > 1) ? $clog2(READ_PORTS)  : 1;
   localparam int WP_W  = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

   logic [RP_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [WP_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [READ_PORTS-1:0]  rd_gnt;
   logic [WRITE_PORTS-1:0] wr_gnt;
   logic [RP_W-1:0]        rd_idx;
   logic [WP_W-1:0]        wr_idx;
   logic                   rd_any, wr_any;
   logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr;
   logic [DATA_WIDTH-1:0]  wr_data;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [READ_PORTS-1:0]  vld_q [DATA_LAT];
   logic [READ_PORTS-1:0]  vld_d [DATA_LAT];
   logic [DATA_WIDTH-1:0]  dat_q [DATA_LAT];
   logic [DATA_WIDTH-1:0]  dat_d [DATA_LAT];

   // Read arbiter: first requester at or after the pointer, wrapping around.
   always_comb begin : rd_arb
      int k;
      k        = 0;
      rd_gnt   = '0;
      rd_idx   = '0;
      rd_any   = 1'b0;
      for (int i = 0; i < READ_PORTS; i++) begin
         k = (int'(rd_ptr_q) + i) % READ_PORTS;
         if (!rd_any && bus.r_avalid[k]) begin
            rd_any    = 1'b1;
            rd_gnt[k] = 1'b1;
            rd_idx    = RP_W'(k);
         end
      end
      rd_ptr_d = rd_ptr_q;
      if (rd_any)
         rd_ptr_d = (int'(rd_idx) == READ_PORTS-1) ? '0 : rd_idx + RP_W'(1);
      rd_addr = bus.r_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Write arbiter: same scheme as the read side, independent pointer.
   always_comb begin : wr_arb
      int k;
      k        = 0;
      wr_gnt   = '0;
      wr_idx   = '0;
      wr_any   = 1'b0;
      for (int i = 0; i < WRITE_PORTS; i++) begin
         k = (int'(wr_ptr_q) + i) % WRITE_PORTS;
         if (!wr_any && bus.w_valid[k]) begin
            wr_any    = 1'b1;
            wr_gnt[k] = 1'b1;
            wr_idx    = WP_W'(k);
         end
      end
      wr_ptr_d = wr_ptr_q;
      if (wr_any)
         wr_ptr_d = (int'(wr_idx) == WRITE_PORTS-1) ? '0 : wr_idx + WP_W'(1);
      wr_addr = bus.w_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data = bus.w_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Read return pipeline: stage 0 captures the pre-write word (read-first).
   always_comb begin
      vld_d[0] = rd_gnt;
      dat_d[0] = mem_q[rd_addr];
      for (int i = 1; i < DATA_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   // Arbiter pointers and read pipeline; reset drops any in-flight reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < DATA_LAT; i++) begin
            vld_q[i] <= '0;
            dat_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         for (int i = 0; i < DATA_LAT; i++) begin
            vld_q[i] <= vld_d[i];
            dat_q[i] <= dat_d[i];
         end
      end
   end

   // Storage array; deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_any)
         mem_q[wr_addr] <= wr_data;
   end

   assign bus.r_aready = rd_gnt;
   assign bus.w_ready  = wr_gnt;
   assign bus.r_dvalid = vld_q[DATA_LAT-1];

   // Only the lane flagged valid carries data; every other lane is zero.
   always_comb begin
      bus.r_data = '0;
      for (int k = 0; k < READ_PORTS; k++) begin
         if (vld_q[DATA_LAT-1][k])
            bus.r_data[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[DATA_LAT-1];
      end
   end
endmodule

// File: tb/tb_arbitrated_multiport_ram.sv
// Bench for arbitrated_multiport_ram: directed vector table, hand-written
// reset/idle sequences, then random traffic against a reference model.
module tb_arbitrated_multiport_ram;
   localparam int RP  = 3;
   localparam int WP  = 3;
   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst;

   arbitrated_multiport_ram_if #(.READ_PORTS(RP), .WRITE_PORTS(WP),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   arbitrated_multiport_ram #(.READ_PORTS(RP), .WRITE_PORTS(WP),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: plain array, pointers as integers, pending reads queue.
   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
      bit          known;
   } rd_t;
   rd_t         pend[$];
   logic [31:0] m_mem   [16];
   bit          m_known [16];
   int          m_rptr, m_wptr, cyc;
   int          last_rg, last_wg;

   typedef struct {
      logic [2:0]  rv;
      logic [11:0] ra;
      logic [2:0]  wv;
      logic [11:0] wa;
      logic [95:0] wd;
      logic [2:0]  erg;
      logic [2:0]  ewg;
      logic [2:0]  edv;
      logic [95:0] erd;
   } vec_t;
   vec_t tbl[18];

   function automatic vec_t mk(input logic [2:0] rv, input logic [11:0] ra,
                               input logic [2:0] wv, input logic [11:0] wa,
                               input logic [95:0] wd, input logic [2:0] erg,
                               input logic [2:0] ewg, input logic [2:0] edv,
                               input logic [95:0] erd);
      vec_t v;
      v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
      v.erg = erg; v.ewg = ewg; v.edv = edv; v.erd = erd;
      return v;
   endfunction

   function automatic logic [95:0] lane(input int k, input logic [31:0] val);
      logic [95:0] v;
      v = '0;
      v[k*32 +: 32] = val;
      return v;
   endfunction

   function automatic int arb(input logic [2:0] req, input int ptr);
      for (int i = 0; i < 3; i++) begin
         if (req[(ptr + i) % 3]) return (ptr + i) % 3;
      end
      return -1;
   endfunction

   function automatic logic [2:0] onehot(input int k);
      logic [2:0] v;
      v = '0;
      if (k >= 0) v[k] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [95:0] act,
                      input logic [95:0] exp, input logic [95:0] mask);
      n_checks++;
      if ((act & mask) === (exp & mask)) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act & mask, exp & mask);
   endtask

   task automatic model_reset();
      pend.delete();
      m_rptr = 0;
      m_wptr = 0;
      cyc    = 0;
   endtask

   task automatic idle_inputs();
      bus.r_avalid = '0;
      bus.r_addr   = '0;
      bus.w_valid  = '0;
      bus.w_addr   = '0;
      bus.w_data   = '0;
   endtask

   // One cycle: sample and check at the falling edge, advance the model at
   // the rising edge, then return 1 time unit later so inputs can change.
   task automatic step(output logic [2:0] s_ra, output logic [2:0] s_wr,
                       output logic [2:0] s_dv, output logic [95:0] s_rd);
      int          rg, wg;
      logic [3:0]  a;
      logic [2:0]  edv;
      logic [95:0] erd, emask;
      @(negedge clk);
      rg = arb(bus.r_avalid, m_rptr);
      wg = arb(bus.w_valid, m_wptr);
      edv = '0; erd = '0; emask = '1;
      foreach (pend[i]) begin
         if (pend[i].due == cyc) begin
            edv[pend[i].port] = 1'b1;
            erd[pend[i].port*32 +: 32] = pend[i].data;
            if (!pend[i].known) emask[pend[i].port*32 +: 32] = '0;
         end
      end
      s_ra = bus.r_aready; s_wr = bus.w_ready;
      s_dv = bus.r_dvalid; s_rd = bus.r_data;
      chk("model r_aready", 96'(s_ra), 96'(onehot(rg)), '1);
      chk("model w_ready",  96'(s_wr), 96'(onehot(wg)), '1);
      chk("model r_dvalid", 96'(s_dv), 96'(edv), '1);
      chk("model r_data",   s_rd, erd, emask);
      last_rg = rg;
      last_wg = wg;
      @(posedge clk);
      if (rg >= 0) begin
         a = bus.r_addr[rg*4 +: 4];
         pend.push_back('{rg, m_mem[a], cyc + LAT, m_known[a]});
         m_rptr = (rg + 1) % 3;
      end
      if (wg >= 0) begin
         a = bus.w_addr[wg*4 +: 4];
         m_mem[a]   = bus.w_data[wg*32 +: 32];
         m_known[a] = 1'b1;
         m_wptr     = (wg + 1) % 3;
      end
      cyc++;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  s_ra, s_wr, s_dv;
      logic [95:0] s_rd;

      for (int i = 0; i < 16; i++) begin
         m_mem[i]   = '0;
         m_known[i] = 1'b0;
      end
      last_rg = -1;
      last_wg = -1;

      tbl[0]  = mk(3'b000, 12'h000, 3'b111, 12'h210, {32'h33, 32'h22, 32'h11}, 3'b000, 3'b001, 3'b000, '0);
      tbl[1]  = mk(3'b000, 12'h000, 3'b110, 12'h210, {32'h33, 32'h22, 32'h11}, 3'b000, 3'b010, 3'b000, '0);
      tbl[2]  = mk(3'b000, 12'h000, 3'b100, 12'h210, {32'h33, 32'h22, 32'h11}, 3'b000, 3'b100, 3'b000, '0);
      tbl[3]  = mk(3'b000, 12'h000, 3'b001, 12'h003, {64'h0, 32'hDEADBEEF},    3'b000, 3'b001, 3'b000, '0);
      tbl[4]  = mk(3'b010, 12'h030, 3'b000, 12'h000, '0, 3'b010, 3'b000, 3'b000, '0);
      tbl[5]  = mk(3'b111, 12'h210, 3'b000, 12'h000, '0, 3'b100, 3'b000, 3'b010, lane(1, 32'hDEADBEEF));
      tbl[6]  = mk(3'b011, 12'h210, 3'b000, 12'h000, '0, 3'b001, 3'b000, 3'b100, lane(2, 32'h33));
      tbl[7]  = mk(3'b010, 12'h210, 3'b000, 12'h000, '0, 3'b010, 3'b000, 3'b001, lane(0, 32'h11));
      tbl[8]  = mk(3'b000, 12'h000, 3'b000, 12'h000, '0, 3'b000, 3'b000, 3'b010, lane(1, 32'h22));
      tbl[9]  = mk(3'b111, 12'h333, 3'b000, 12'h000, '0, 3'b100, 3'b000, 3'b000, '0);
      tbl[10] = mk(3'b111, 12'h333, 3'b000, 12'h000, '0, 3'b001, 3'b000, 3'b100, lane(2, 32'hDEADBEEF));
      tbl[11] = mk(3'b111, 12'h333, 3'b000, 12'h000, '0, 3'b010, 3'b000, 3'b001, lane(0, 32'hDEADBEEF));
      tbl[12] = mk(3'b111, 12'h333, 3'b000, 12'h000, '0, 3'b100, 3'b000, 3'b010, lane(1, 32'hDEADBEEF));
      tbl[13] = mk(3'b000, 12'h000, 3'b000, 12'h000, '0, 3'b000, 3'b000, 3'b100, lane(2, 32'hDEADBEEF));
      tbl[14] = mk(3'b000, 12'h000, 3'b010, 12'h050, {32'h0, 32'hA, 32'h0}, 3'b000, 3'b010, 3'b000, '0);
      tbl[15] = mk(3'b001, 12'h005, 3'b100, 12'h500, {32'hB, 64'h0},        3'b001, 3'b100, 3'b000, '0);
      tbl[16] = mk(3'b010, 12'h050, 3'b000, 12'h000, '0, 3'b010, 3'b000, 3'b001, lane(0, 32'hA));
      tbl[17] = mk(3'b000, 12'h000, 3'b000, 12'h000, '0, 3'b000, 3'b000, 3'b010, lane(1, 32'hB));

      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset r_dvalid", 96'(bus.r_dvalid), '0, '1);
      chk("reset r_data", bus.r_data, '0, '1);
      rst = 1'b1;
      model_reset();

      for (int i = 0; i < 18; i++) begin
         bus.r_avalid = tbl[i].rv;
         bus.r_addr   = tbl[i].ra;
         bus.w_valid  = tbl[i].wv;
         bus.w_addr   = tbl[i].wa;
         bus.w_data   = tbl[i].wd;
         step(s_ra, s_wr, s_dv, s_rd);
         chk($sformatf("tbl%0d r_aready", i), 96'(s_ra), 96'(tbl[i].erg), '1);
         chk($sformatf("tbl%0d w_ready", i),  96'(s_wr), 96'(tbl[i].ewg), '1);
         chk($sformatf("tbl%0d r_dvalid", i), 96'(s_dv), 96'(tbl[i].edv), '1);
         chk($sformatf("tbl%0d r_data", i),   s_rd, tbl[i].erd, '1);
      end

      // Reset pulse with a read in flight: the read must never return.
      idle_inputs();
      bus.r_avalid = 3'b100;
      bus.r_addr   = 12'h333;
      step(s_ra, s_wr, s_dv, s_rd);
      chk("inflight grant", 96'(s_ra), 96'(3'b100), '1);
      idle_inputs();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      step(s_ra, s_wr, s_dv, s_rd);
      chk("post-reset r_dvalid", 96'(s_dv), '0, '1);
      chk("post-reset r_data", s_rd, '0, '1);
      bus.r_avalid = 3'b111;
      bus.r_addr   = 12'h333;
      step(s_ra, s_wr, s_dv, s_rd);
      chk("post-reset first grant", 96'(s_ra), 96'(3'b001), '1);
      idle_inputs();
      step(s_ra, s_wr, s_dv, s_rd);
      chk("post-reset read dvalid", 96'(s_dv), 96'(3'b001), '1);
      chk("post-reset read data", s_rd, lane(0, 32'hDEADBEEF), '1);

      // Ten idle cycles: everything quiet, pointers hold.
      for (int i = 0; i < 10; i++) begin
         step(s_ra, s_wr, s_dv, s_rd);
         chk($sformatf("idle%0d outputs", i), {s_rd[89:0], s_ra, s_wr}, '0, '1);
         chk($sformatf("idle%0d r_dvalid", i), 96'(s_dv), '0, '1);
      end
      bus.r_avalid = 3'b111;
      bus.r_addr   = 12'h333;
      bus.w_valid  = 3'b111;
      bus.w_addr   = 12'h777;
      bus.w_data   = {32'h3, 32'h2, 32'h1};
      step(s_ra, s_wr, s_dv, s_rd);
      chk("idle-held read pointer", 96'(s_ra), 96'(3'b010), '1);
      chk("idle-held write pointer", 96'(s_wr), 96'(3'b001), '1);

      // Random traffic; an ungranted requester holds its request unchanged.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 3; p++) begin
            if (!(bus.r_avalid[p] && last_rg != p)) begin
               bus.r_avalid[p]      = 1'($urandom_range(0, 1));
               bus.r_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
            end
            if (!(bus.w_valid[p] && last_wg != p)) begin
               bus.w_valid[p]        = 1'($urandom_range(0, 1));
               bus.w_addr[p*4 +: 4]  = 4'($urandom_range(0, 15));
               bus.w_data[p*32 +: 32] = $urandom;
            end
         end
         step(s_ra, s_wr, s_dv, s_rd);
      end
      idle_inputs();
      repeat (LAT + 1) step(s_ra, s_wr, s_dv, s_rd);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
